// File: rtl/rotate_engine.sv
// rtl/rotate_engine.sv - rho-rotation engine: buffers a sliced 5x5-lane state and streams it out rotated
module rotate_engine #(
    parameter int LANE_W = 64,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_data,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             done
);

    // Slice index width; a one-slice state still needs a 1-bit index to address the buffer.
    localparam int IDX_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(LANE_W - 1);
    localparam logic [6:0]       IDX_MASK = 7'(LANE_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Rho offsets in lane order i = x + 5*y; reduced mod LANE_W by masking the source index.
    localparam logic [5:0] ROT [25] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [24:0]      slice_q [LANE_W];
    logic [24:0]      rot_data;
    logic [6:0]       src;

    // Next-state and counter logic; start is only honoured in IDLE, which also freezes the mode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = inverse;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_EMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Slice buffer: written in arrival order, contents are meaningless until reloaded so no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid) begin
            slice_q[cnt_q[IDX_W-1:0]] <= in_data;
        end
    end

    // Gather each lane bit from the slice it rotates out of; 7-bit wrap is a multiple of LANE_W.
    always_comb begin
        rot_data = '0;
        src      = '0;
        for (int i = 0; i < 25; i++) begin
            if (mode_q) begin
                src = 7'(cnt_q) + 7'(ROT[i]);
            end else begin
                src = 7'(cnt_q) - 7'(ROT[i]);
            end
            src         = src & IDX_MASK;
            rot_data[i] = slice_q[src[IDX_W-1:0]][i];
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_EMIT);
    assign busy      = (state_q == S_LOAD) || (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign out_idx   = cnt_q;
    assign out_data  = out_valid ? rot_data : 25'd0;

endmodule

// File: tb/tb_rotate_engine.sv
// tb/tb_rotate_engine.sv - self-checking bench for rotate_engine (LANE_W=64 and LANE_W=8 builds)
module tb_rotate_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, inverse, in_valid, out_ready, sel;
    logic [24:0] in_data;

    logic        in_ready_a, out_valid_a, busy_a, done_a;
    logic [24:0] out_data_a;
    logic [5:0]  out_idx_a;
    logic        in_ready_b, out_valid_b, busy_b, done_b;
    logic [24:0] out_data_b;
    logic [5:0]  out_idx_b;

    logic        in_ready, out_valid, busy, done;
    logic [24:0] out_data;
    logic [5:0]  out_idx;

    rotate_engine #(.LANE_W(64), .CNT_W(6)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .inverse(inverse),
        .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready & ~sel), .out_data(out_data_a),
        .out_idx(out_idx_a), .busy(busy_a), .done(done_a)
    );

    rotate_engine #(.LANE_W(8), .CNT_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .inverse(inverse),
        .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready & sel), .out_data(out_data_b),
        .out_idx(out_idx_b), .busy(busy_b), .done(done_b)
    );

    assign in_ready  = sel ? in_ready_b  : in_ready_a;
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign busy      = sel ? busy_b      : busy_a;
    assign done      = sel ? done_b      : done_a;
    assign out_data  = sel ? out_data_b  : out_data_a;
    assign out_idx   = sel ? out_idx_b   : out_idx_a;

    int ROT [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    logic [24:0] stim [64];
    logic [24:0] expd [64];
    logic [24:0] got  [64];
    logic [24:0] orig [64];
    logic [24:0] nostall [64];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          lw;
        bit          inv;
        int          z;
        logic [24:0] exp;
    } vec_t;
    vec_t vt [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: treat each lane as an L-bit word and rotate it as a whole.
    task automatic model(input int L, input bit inv);
        logic [63:0] lane, r, mask;
        int e;
        mask = (L == 64) ? {64{1'b1}} : ((64'd1 << L) - 64'd1);
        for (int z = 0; z < 64; z++) expd[z] = '0;
        for (int i = 0; i < 25; i++) begin
            lane = '0;
            for (int z = 0; z < L; z++) lane[z] = stim[z][i];
            e = ROT[i] % L;
            if (!inv) r = ((lane << e) | (lane >> (L - e))) & mask;
            else      r = ((lane >> e) | (lane << (L - e))) & mask;
            for (int z = 0; z < L; z++) expd[z][i] = r[z];
        end
    endtask

    task automatic rand_stim();
        for (int z = 0; z < 64; z++) stim[z] = 25'($urandom);
    endtask

    task automatic run_op(input int L, input bit inv, input int in_stall, input int out_stall,
                          input bit noise, input string tag);
        int i, k, cyc, dones, budget;
        bit hs, held;
        logic [24:0] hd;
        logic [5:0]  hi;
        sel    = (L == 8);
        budget = 20 * L + 50;
        model(L, inv);
        dones = 0;
        start = 1'b1; inverse = inv;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0; cyc = 0;
        while (i < L && cyc < budget) begin
            in_valid = ($urandom_range(99) >= in_stall);
            in_data  = stim[i];
            if (noise) begin start = 1'($urandom_range(1)); inverse = 1'($urandom_range(1)); end
            @(negedge clk);
            if (done) dones++;
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) i++;
            cyc++;
        end
        in_valid = 1'b0;
        if (i < L) chk($sformatf("%s load_timeout", tag), 64'(i), 64'(L));
        if (in_stall == 0) chk($sformatf("%s load_cycles", tag), 64'(cyc), 64'(L));
        k = 0; held = 0; cyc = 0; hd = '0; hi = '0;
        while (k < L && cyc < budget) begin
            out_ready = ($urandom_range(99) >= out_stall);
            if (noise) begin start = 1'($urandom_range(1)); inverse = 1'($urandom_range(1)); end
            @(negedge clk);
            if (done) dones++;
            if (out_valid) begin
                if (held) begin
                    chk($sformatf("%s hold_data", tag), 64'(out_data), 64'(hd));
                    chk($sformatf("%s hold_idx", tag), 64'(out_idx), 64'(hi));
                end
                if (out_ready) begin
                    chk($sformatf("%s idx_order", tag), 64'(out_idx), 64'(k));
                    got[k] = out_data;
                    k++;
                    held = 0;
                end else begin
                    held = 1; hd = out_data; hi = out_idx;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (k < L) chk($sformatf("%s emit_timeout", tag), 64'(k), 64'(L));
        if (out_stall == 0) chk($sformatf("%s emit_cycles", tag), 64'(cyc), 64'(L));
        // A start raised in the DONE cycle must be ignored.
        start = noise;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("%s done_pulses", tag), 64'(dones), 64'd1);
        chk($sformatf("%s idle_busy", tag), 64'(busy), 64'd0);
        chk($sformatf("%s idle_in_ready", tag), 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        for (int z = 0; z < L; z++) chk($sformatf("%s slice%0d", tag, z), 64'(got[z]), 64'(expd[z]));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk($sformatf("%s in_ready", tag), 64'(in_ready), 64'd0);
        chk($sformatf("%s out_valid", tag), 64'(out_valid), 64'd0);
        chk($sformatf("%s busy", tag), 64'(busy), 64'd0);
        chk($sformatf("%s done", tag), 64'(done), 64'd0);
        chk($sformatf("%s out_idx", tag), 64'(out_idx), 64'd0);
        chk($sformatf("%s out_data", tag), 64'(out_data), 64'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; inverse = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; sel = 1'b0;

        vt[0]  = '{64, 1'b0, 0,  25'h0000001};
        vt[1]  = '{64, 1'b0, 1,  25'h0000002};
        vt[2]  = '{64, 1'b0, 2,  25'h0200000};
        vt[3]  = '{64, 1'b0, 3,  25'h0000400};
        vt[4]  = '{64, 1'b0, 62, 25'h0000004};
        vt[5]  = '{64, 1'b1, 0,  25'h0000001};
        vt[6]  = '{64, 1'b1, 63, 25'h0000002};
        vt[7]  = '{64, 1'b1, 62, 25'h0200000};
        vt[8]  = '{64, 1'b1, 2,  25'h0000004};
        vt[9]  = '{8,  1'b0, 6,  25'h1000084};
        vt[10] = '{8,  1'b0, 4,  25'h0000268};
        vt[11] = '{8,  1'b0, 1,  25'h000A002};
        vt[12] = '{8,  1'b0, 0,  25'h0880001};

        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; chk_outputs_zero("reset64");
        sel = 1'b1; chk_outputs_zero("reset8");
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer vectors: slice 0 all ones, others zero.
        for (int v = 0; v < 13; v++) begin
            for (int z = 0; z < 64; z++) stim[z] = '0;
            stim[0] = 25'h1FFFFFF;
            run_op(vt[v].lw, vt[v].inv, 0, 0, 1'b0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d z%0d", v, vt[v].z), 64'(got[vt[v].z]), 64'(vt[v].exp));
        end

        // Forward then inverse reproduces the original state.
        for (int n = 0; n < 2; n++) begin
            rand_stim();
            for (int z = 0; z < 64; z++) orig[z] = stim[z];
            run_op(64, 1'b0, 0, 0, 1'b0, "rt_fwd");
            for (int z = 0; z < 64; z++) stim[z] = got[z];
            run_op(64, 1'b1, 0, 0, 1'b0, "rt_inv");
            for (int z = 0; z < 64; z++) chk($sformatf("roundtrip z%0d", z), 64'(got[z]), 64'(orig[z]));
        end

        // LANE_W=8 random states, both modes, alternating backpressure.
        for (int n = 0; n < 100; n++) begin
            rand_stim();
            run_op(8, 1'b0, (n % 2) * 50, (n % 2) * 50, 1'b0, "l8_fwd");
            run_op(8, 1'b1, (n % 2) * 50, (n % 2) * 50, 1'b0, "l8_inv");
        end

        // Backpressure result equals the no-stall result.
        rand_stim();
        run_op(64, 1'b1, 0, 0, 1'b0, "bp_ref");
        for (int z = 0; z < 64; z++) nostall[z] = got[z];
        run_op(64, 1'b1, 50, 50, 1'b0, "bp_stall");
        for (int z = 0; z < 64; z++) chk($sformatf("bp_vs_nostall z%0d", z), 64'(got[z]), 64'(nostall[z]));

        // start/inverse noise while busy and in DONE.
        rand_stim();
        run_op(64, 1'b0, 30, 30, 1'b1, "noise64_fwd");
        rand_stim();
        run_op(8, 1'b1, 30, 30, 1'b1, "noise8_inv");

        // Reset in EMIT at slice 17, then a fresh operation.
        sel = 1'b0;
        rand_stim();
        start = 1'b1; inverse = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int z = 0; z < 64; z++) begin
            in_data = stim[z];
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (out_valid && out_idx == 6'd17) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_reach_idx17", 64'(out_idx), 64'd17);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        chk_outputs_zero("midrst");
        @(posedge clk); #1;
        chk_outputs_zero("midrst_idle");
        rand_stim();
        run_op(64, 1'b0, 0, 0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
